// File: rtl/move_queue_pkg.sv
// Shared constants and types for the move queue: command opcodes, entry layout,
// configuration reset values and parser state encoding.
package move_queue_pkg;
  localparam logic [7:0] OP_MOVE  = 8'h01;
  localparam logic [7:0] OP_DIV   = 8'h03;
  localparam logic [7:0] OP_USTEP = 8'h04;
  localparam logic [7:0] OP_FLUSH = 8'h05;

  localparam int ENTRY_W = 120;

  localparam logic [23:0] DIV_RST   = 24'd32;
  localparam logic [2:0]  USTEP_RST = 3'd1;

  typedef enum logic [1:0] {IDLE, W_DUR, W_INC, W_INCINC} parse_state_e;

  typedef struct packed {
    logic [23:0] dir;
    logic [31:0] dur;
    logic [31:0] inc;
    logic [31:0] incinc;
  } move_entry_t;
endpackage

// File: rtl/move_fifo.sv
// Synchronous first-word-fall-through FIFO; flush has priority over push/pop and
// a push into a full FIFO is accepted only when a pop frees a slot that same cycle.
module move_fifo #(
  parameter int WIDTH = 120,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd, r_wr;
  logic [CW-1:0]    r_count;
  logic             w_pop, w_push;

  assign valid  = (r_count != '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_pop  = pop && valid;
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rd];
  assign count  = r_count;

  // Storage is cleared on reset so the head never shows X while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/move_queue.sv
// Command word parser feeding a FIFO of step-generator moves; also holds the
// clock divisor / microstep configuration and a sticky overflow flag.
module move_queue
  import move_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   word_received,
  input  logic [31:0]            word_data,
  input  logic                   move_ready,
  output logic                   move_valid,
  output logic [23:0]            move_dir,
  output logic [31:0]            move_duration,
  output logic [31:0]            move_increment,
  output logic [31:0]            move_incrementincrement,
  output logic [23:0]            clock_divisor,
  output logic [2:0]             microsteps,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   overflow
);
  parse_state_e r_state, w_state;
  logic [23:0]  r_dir, r_clk_div;
  logic [31:0]  r_dur, r_inc;
  logic [2:0]   r_usteps;
  logic         r_overflow;
  logic [7:0]   w_hdr;
  logic         w_push, w_flush, w_pop, w_full, w_valid;
  move_entry_t  w_in, w_head;

  assign w_hdr = word_data[31:24];

  always_comb begin
    w_state = r_state;
    w_push  = 1'b0;
    w_flush = 1'b0;
    if (word_received) begin
      case (r_state)
        IDLE: begin
          if (w_hdr == OP_MOVE)       w_state = W_DUR;
          else if (w_hdr == OP_FLUSH) w_flush = 1'b1;
        end
        W_DUR:    w_state = W_INC;
        W_INC:    w_state = W_INCINC;
        W_INCINC: begin
          w_state = IDLE;
          w_push  = 1'b1;
        end
        default:  w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_dir      <= '0;
      r_dur      <= '0;
      r_inc      <= '0;
      r_clk_div  <= DIV_RST;
      r_usteps   <= USTEP_RST;
      r_overflow <= 1'b0;
    end else begin
      if (word_received) begin
        case (r_state)
          IDLE: begin
            case (w_hdr)
              OP_MOVE:  r_dir     <= word_data[23:0];
              OP_DIV:   r_clk_div <= word_data[23:0];
              OP_USTEP: if (word_data[2:0] inside {3'd1, 3'd2, 3'd4}) r_usteps <= word_data[2:0];
              default: ;
            endcase
          end
          W_DUR:   r_dur <= word_data;
          W_INC:   r_inc <= word_data;
          default: ;
        endcase
      end
      // Only a move dropped for lack of space counts; a same-cycle pop makes room.
      if (w_flush)                         r_overflow <= 1'b0;
      else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // The final payload word goes straight into the entry without being registered.
  assign w_in  = {r_dir, r_dur, r_inc, word_data};
  assign w_pop = w_valid && move_ready;

  move_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .reset (reset),
    .push  (w_push),
    .din   (w_in),
    .pop   (w_pop),
    .flush (w_flush),
    .dout  (w_head),
    .valid (w_valid),
    .full  (w_full),
    .count (queue_count)
  );

  assign move_valid              = w_valid;
  assign move_dir                = w_head.dir;
  assign move_duration           = w_head.dur;
  assign move_increment          = w_head.inc;
  assign move_incrementincrement = w_head.incinc;
  assign clock_divisor           = r_clk_div;
  assign microsteps              = r_usteps;
  assign overflow                = r_overflow;
endmodule

// File: tb/tb_move_queue.sv
// Scoreboard bench for move_queue: the stimulus pushes expected entries, and a
// negedge monitor checks every entry the DUT hands off (valid && ready).
module tb_move_queue;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        reset, word_received, move_ready;
  logic [31:0] word_data;
  logic        move_valid, overflow;
  logic [23:0] move_dir, clock_divisor;
  logic [31:0] move_duration, move_increment, move_incrementincrement;
  logic [2:0]  microsteps;
  logic [$clog2(DEPTH):0] queue_count;

  move_queue #(.DEPTH(DEPTH)) dut (
    .CLK                     (CLK),
    .reset                   (reset),
    .word_received           (word_received),
    .word_data               (word_data),
    .move_ready              (move_ready),
    .move_valid              (move_valid),
    .move_dir                (move_dir),
    .move_duration           (move_duration),
    .move_increment          (move_increment),
    .move_incrementincrement (move_incrementincrement),
    .clock_divisor           (clock_divisor),
    .microsteps              (microsteps),
    .queue_count             (queue_count),
    .overflow                (overflow)
  );

  always #5 CLK = ~CLK;

  logic [119:0] exp_q[$];
  logic [119:0] mon_exp, mon_got;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change at posedge+1, so valid && ready at the negedge is exactly
  // the handshake the following posedge consumes.
  always @(negedge CLK) begin
    if (!reset && move_valid && move_ready) begin
      checks++;
      mon_got = {move_dir, move_duration, move_increment, move_incrementincrement};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h expected no entry", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL pop_entry: got %h expected %h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    word_received = 1'b1;
    word_data     = w;
    @(posedge CLK);
    #1;
    word_received = 1'b0;
    word_data     = 32'h0;
  endtask

  task automatic send_move(input logic [23:0] d, input logic [31:0] dur,
                           input logic [31:0] inc, input logic [31:0] ii, input bit accept);
    send({8'h01, d});
    send(dur);
    send(inc);
    if (accept) exp_q.push_back({d, dur, inc, ii});
    send(ii);
  endtask

  initial begin
    reset = 1'b1; word_received = 1'b0; word_data = 32'h0; move_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    chk("rst_count", 32'(queue_count), 32'd0);
    chk("rst_valid", 32'(move_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_divisor", 32'(clock_divisor), 32'd32);
    chk("rst_microsteps", 32'(microsteps), 32'd1);

    // Basic move: valid exactly one cycle after the fourth strobe
    send(32'h01000005); send(32'h00001000); send(32'h00000064);
    chk("t1_valid_before", 32'(move_valid), 32'd0);
    exp_q.push_back({24'h000005, 32'h1000, 32'd100, 32'd1});
    send(32'h00000001);
    chk("t1_valid", 32'(move_valid), 32'd1);
    chk("t1_count", 32'(queue_count), 32'd1);
    chk("t1_dir", 32'(move_dir), 32'h5);
    chk("t1_dur", move_duration, 32'h1000);
    chk("t1_inc", move_increment, 32'd100);
    chk("t1_incinc", move_incrementincrement, 32'd1);
    move_ready = 1'b1;
    tick(1);
    chk("t1_valid_after_pop", 32'(move_valid), 32'd0);
    move_ready = 1'b0;

    // Five moves into four slots: last one dropped, overflow sticky
    for (int i = 0; i < 5; i++)
      send_move(24'h10 + 24'(i), 32'h100 * (i + 1), 32'(i), -32'(i), i < 4);
    chk("t2_count_full", 32'(queue_count), 32'd4);
    chk("t2_overflow", 32'(overflow), 32'd1);
    move_ready = 1'b1;
    tick(5);
    move_ready = 1'b0;
    chk("t2_count_drained", 32'(queue_count), 32'd0);
    chk("t2_overflow_sticky", 32'(overflow), 32'd1);
    send(32'h05000000);
    chk("t2_overflow_cleared", 32'(overflow), 32'd0);

    // Full queue, fifth push coincides with a pop: both succeed
    for (int i = 0; i < 4; i++)
      send_move(24'h20 + 24'(i), 32'h1000 + 32'(i), 32'h7 * 32'(i), 32'h3, 1'b1);
    send(32'h010000AA); send(32'h0000BEEF); send(32'hFFFFFFFE);
    exp_q.push_back({24'h0000AA, 32'h0000BEEF, 32'hFFFFFFFE, 32'h12345678});
    move_ready = 1'b1;
    send(32'h12345678);
    move_ready = 1'b0;
    chk("t3_count", 32'(queue_count), 32'd4);
    chk("t3_overflow", 32'(overflow), 32'd0);
    move_ready = 1'b1;
    tick(4);
    move_ready = 1'b0;
    chk("t3_count_drained", 32'(queue_count), 32'd0);

    // Configuration words and an unknown header
    send(32'h03000100);
    chk("t4_div_100", 32'(clock_divisor), 32'h100);
    send(32'h03000020);
    chk("t4_div_20", 32'(clock_divisor), 32'h20);
    send(32'h04000003);
    chk("t4_ustep_bad", 32'(microsteps), 32'd1);
    send(32'h04000004);
    chk("t4_ustep_4", 32'(microsteps), 32'd4);
    send(32'h04000002);
    chk("t4_ustep_2", 32'(microsteps), 32'd2);
    send(32'h02ABCDEF);
    chk("t4_unknown_div", 32'(clock_divisor), 32'h20);
    chk("t4_unknown_count", 32'(queue_count), 32'd0);

    // Reset mid-message discards the partial move and restores config
    send(32'h01000007); send(32'h00002000); send(32'h00000011);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t5_rst_div", 32'(clock_divisor), 32'd32);
    chk("t5_rst_ustep", 32'(microsteps), 32'd1);
    send_move(24'h000009, 32'h05000000, 32'hFFFFFFF6, 32'h80000000, 1'b1);
    chk("t5_count", 32'(queue_count), 32'd1);
    move_ready = 1'b1;
    tick(1);
    move_ready = 1'b0;
    chk("t5_count_after_pop", 32'(queue_count), 32'd0);

    // Flush of two queued moves, coinciding with a pop
    send_move(24'h000031, 32'h10, 32'h20, 32'h30, 1'b1);
    send_move(24'h000032, 32'h11, 32'h21, 32'h31, 1'b1);
    chk("t6_count_before", 32'(queue_count), 32'd2);
    move_ready = 1'b1;
    send(32'h05000000);
    move_ready = 1'b0;
    exp_q.delete();
    chk("t6_count", 32'(queue_count), 32'd0);
    chk("t6_valid", 32'(move_valid), 32'd0);
    chk("t6_overflow", 32'(overflow), 32'd0);

    tick(2);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/move_queue.md
MOVE_QUEUE -- requirements
Module: move_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning move entries held; power of two, 2..16.
REQ-002 SHALL have port CLK  input  1  system clock; all logic rising-edge on CLK.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port word_received  input  1  one-cycle strobe, CLK-synchronous, one per 32-bit word; back-to-back strobes legal.
REQ-005 SHALL have port word_data  input  32  received word, valid while word_received high.
REQ-006 SHALL have port move_ready  input  1  step generator can accept a move.
REQ-007 SHALL have port move_valid  output  1  head entry present.
REQ-008 SHALL have port move_dir  output  24  head entry direction bits.
REQ-009 SHALL have port move_duration  output  32  head entry duration, in ticks.
REQ-010 SHALL have port move_increment  output  32  head entry increment, signed.
REQ-011 SHALL have port move_incrementincrement  output  32  head entry increment-increment, signed.
REQ-012 SHALL have port clock_divisor  output  24  tick divisor.
REQ-013 SHALL have port microsteps  output  3  microstep setting.
REQ-014 SHALL have port queue_count  output  clog2(DEPTH)+1  entries held.
REQ-015 SHALL have port overflow  output  1  sticky: a complete move was dropped.

Function
REQ-016 Parser FSM SHALL have states IDLE, W_DUR, W_INC, W_INCINC and SHALL act only on cycles with word_received=1.
REQ-017 In IDLE, header = word_data[31:24].
- 0x01: latch dir = word_data[23:0], go to W_DUR.
- 0x03: clock_divisor <= word_data[23:0].
- 0x04: microsteps <= word_data[2:0] only if the value is 1, 2 or 4; otherwise ignore.
- 0x05: flush queue and clear overflow.
- Any other header: ignore and stay in IDLE.
REQ-018 Payload words in W_DUR, W_INC and W_INCINC SHALL be taken whole (32 bits), whatever their value: W_DUR -> W_INC -> W_INCINC -> IDLE.
REQ-019 On the W_INCINC word, push entry {dir, duration, increment, incincrement} into the queue in that same cycle.
REQ-020 move_valid, outputs and queue_count SHALL update on the edge after the push: one cycle push-to-valid.
REQ-021 Queue SHALL be first-word-fall-through: move_* outputs show the head entry whenever move_valid=1.
REQ-022 move_valid = (queue_count != 0).
REQ-023 Pop SHALL occur on a cycle with move_valid and move_ready both high; the next entry, or move_valid=0, is visible on the following cycle.
REQ-024 Push when full with no pop in that cycle: drop the entry, set overflow, leave queue_count unchanged.
REQ-025 Push and pop in the same cycle SHALL both succeed, even when full; queue_count is unchanged.
REQ-026 Flush and pop in the same cycle: flush wins, and queue_count becomes 0.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; queue_count SHALL never exceed DEPTH or underflow.
REQ-028 move_* outputs when move_valid=0: don't-care, but stable (no X propagation).

Reset
REQ-029 While reset is high:
- parser returns to IDLE, and any partial message is discarded;
- queue is emptied: queue_count=0, move_valid=0;
- overflow=0, clock_divisor=32, microsteps=1.
REQ-030 Reset SHALL override word_received and move_ready in the same cycle.

Structure
REQ-031 The shared package SHALL hold:
- opcode constants (0x01, 0x03, 0x04, 0x05);
- entry width: 120 bits;
- reset defaults (divisor 32, microsteps 1);
- parser state encoding.
REQ-032 Storage SHALL be one sub-module, move_fifo: a synchronous FWFT FIFO, parameterised by width and DEPTH, with push/pop/flush ports and a count output; the parser stays in move_queue.

Verification
REQ-033 Words 0x01000005, 0x00001000, 0x00000064, 0x00000001 -> move_valid high one cycle after the fourth strobe; dir=0x000005, duration=0x1000, increment=100, incincrement=1.
REQ-034 Five moves at DEPTH=4, move_ready=0 -> queue_count=4, overflow=1, and the first four entries pop in order when move_ready=1.
REQ-035 With queue full, a fifth push in the same cycle as a pop -> no overflow, queue_count stays 4, and the new entry arrives last.
REQ-036 0x03000020 then 0x04000003 -> clock_divisor=0x20, microsteps unchanged; 0x04000004 -> microsteps=4.
REQ-037 Reset asserted after the W_INC word, then the full four-word move -> exactly one entry queued, with the values of the post-reset words.
REQ-038 Two queued moves, then 0x05000000 -> queue_count=0, move_valid=0, overflow=0 on the next cycle.
